rtc_time_display: RTL and testbench
===================================

Name: rtc_time_display

Overview:
- Parametrised real-time clock core with keypad time entry and 2x16 LCD line formatter.
- Counts seconds from CLK via prescaler, holds HOUR/MIN/SEC in 12h or 24h form, and accepts digit-by-digit set entry through a state machine.
- Drives the 256-bit TIME_DATA bus consumed by the LCD controller.

Parameters:
- CLK_HZ, 1000, CLK cycles per second tick; minimum 2.
- MODE_24H, 0, selects clock format: 0 = 12h with AM/PM, 1 = 24h.
- BLANK_CHAR, 8'h20, ASCII code placed in every unused LCD cell.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- NUM_SYNC  in  4  keypad code, synchronised; 0-9 digit, 4'hA AM/PM toggle, others ignored.
- NUM_VALID  in  1  one-cycle strobe qualifying NUM_SYNC.
- MODE  in  4  4'b0001 = time set; any other value = run.
- TIME_DATA  out  256  LCD characters; byte k = TIME_DATA[8k+7:8k]; bytes 0-15 line 1, 16-31 line 2, left to right.
- MERIDIEM  out  1  0 = AM, 1 = PM; constant 0 when MODE_24H=1.
- HOUR  out  7  binary hour.
- MIN  out  7  binary minute.
- SEC  out  7  binary second.
- SEC_PULSE  out  1  one-cycle pulse when the time advances.
- SET_ACTIVE  out  1  high while the FSM is in any entry state.

Behaviour:
- Reset values:
  - 12h mode: 12:00:00, MERIDIEM=0.
  - 24h mode: 00:00:00.
  - Prescaler 0, SEC_PULSE 0, SET_ACTIVE 0, FSM RUN, alarm disarmed.
  - TIME_DATA shows the reset time.
- Prescaler:
  - Counts 0..CLK_HZ-1.
  - At the terminal count it wraps to 0, SEC_PULSE=1 for that cycle, and the time registers advance at the same edge.
- Increment:
  - Seconds wrap 59->0 and carry into minutes; minutes wrap 59->0 and carry into hours.
  - 24h: hours wrap 23->0.
  - 12h: 11->12 toggles MERIDIEM; 12->1 leaves MERIDIEM unchanged.
- Time keeps running in every FSM state.
- FSM states: RUN, H10, H1, M10, M1, S10, S1, COMMIT.
  - RUN->H10: when MODE==4'b0001. Shadow digits cleared to "unset"; shadow meridiem copied from live time.
  - Hn/Mn/Sn: a NUM_VALID digit 0-9 stores the digit and advances to the next state; S1 advances to COMMIT.
  - A NUM_VALID code 4'hA toggles shadow meridiem (12h only) without advancing.
  - Codes 4'hB-4'hF are ignored.
  - COMMIT (one cycle): range-check the shadow value.
    - Valid ranges: hour 1-12 (12h) or 0-23 (24h); min/sec 0-59.
    - Valid: load live time and shadow meridiem, and clear prescaler to 0.
    - Invalid: discard, live time unchanged.
    - Then go to H10 if MODE still 4'b0001, else RUN.
  - MODE leaving 4'b0001 in any entry state aborts to RUN next cycle with no load.
- Simultaneous events:
  - A commit load on the same edge as a prescaler terminal count wins: loaded value held, no increment, SEC_PULSE still asserted.
  - NUM_VALID in RUN is ignored.
- Display (registered, 1-cycle latency after any time/shadow change):
  - Line 1 in RUN: all BLANK_CHAR.
  - Line 1 in entry states: byte 0-1 blank; 2-4 "SET"; 5 blank; 6-7 shadow hour; 8 ':'; 9-10 shadow min; 11 ':'; 12-13 shadow sec; 14 blank; 15 shadow 'A'/'P' (blank in 24h).
  - Unset shadow digits display '_' (8'h5F).
  - Line 2: bytes 16-19 blank; 20 'A'/'P' and 21 'M' in 12h (both blank in 24h); 22 blank; 23-24 hour tens/units ASCII; 25 ':'; 26-27 min; 28 ':'; 29-30 sec; 31 blank.
- Reset asserted mid-entry returns immediately to reset values and discards the shadow.

Optional Feature:
- Macro: TIME_ALARM_EN.
- Defined:
  - Adds output ALARM_MATCH (1).
  - MODE 4'b0010 runs the same entry FSM into alarm registers instead of live time.
  - A successful alarm commit arms the alarm and does not clear the prescaler.
  - ALARM_MATCH is a one-cycle pulse, coincident with SEC_PULSE, when the new time equals the alarm (including meridiem) while armed.
  - Line 2 byte 31 shows '*' (8'h2A) when armed.
- Undefined:
  - No ALARM_MATCH port.
  - MODE 4'b0010 behaves as run.
  - Byte 31 always blank.

Test Plan:
- Reset then release, CLK_HZ=4, 12h:
  - TIME_DATA line 2 reads "    AM 12:00:00 ".
  - SEC_PULSE every 4 cycles; SEC=1 after the first pulse.
- Preload 11:59:59 AM, one tick -> 12:00:00, MERIDIEM=1. Preload 12:59:59 PM, one tick -> 01:00:00, MERIDIEM=1.
- MODE_24H=1, preload 23:59:59, one tick -> 00:00:00, MERIDIEM=0.
- MODE=0001, digits 0,9,3,0,4,5, code A:
  - Line 1 shows "_" placeholders progressively.
  - After COMMIT: HOUR=9, MIN=30, SEC=45, MERIDIEM toggled, prescaler 0.
- Entry 1,3,0,0,0,0 in 12h -> commit rejected, live time unchanged.
- MODE dropped to 0000 after the second digit -> FSM in RUN next cycle, no load.
- Assert RESET mid-entry -> all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/rtc_time_display.sv
// Real-time clock with keypad set entry and a 2x16 LCD line formatter.
// Optional alarm (ALARM_MATCH port, MODE 4'b0010 entry) is enabled by defining TIME_ALARM_EN.
module rtc_time_display #(
    parameter int         CLK_HZ     = 1000,
    parameter int         MODE_24H   = 0,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   NUM_SYNC,
    input  logic         NUM_VALID,
    input  logic [3:0]   MODE,
    output logic [255:0] TIME_DATA,
    output logic         MERIDIEM,
    output logic [6:0]   HOUR,
    output logic [6:0]   MIN,
    output logic [6:0]   SEC,
    output logic         SEC_PULSE,
`ifdef TIME_ALARM_EN
    output logic         ALARM_MATCH,
`endif
    output logic         SET_ACTIVE
);

    localparam bit IS24 = (MODE_24H != 0);
    localparam int PW   = $clog2(CLK_HZ);

    typedef enum logic [2:0] {
        ST_RUN, ST_H10, ST_H1, ST_M10, ST_M1, ST_S10, ST_S1, ST_COMMIT
    } state_t;

    typedef struct packed {
        logic [6:0] hr;
        logic [6:0] mn;
        logic [6:0] sc;
        logic       mer;
    } time_t;

    localparam time_t RESET_TIME = '{hr: (IS24 ? 7'd0 : 7'd12), mn: 7'd0, sc: 7'd0, mer: 1'b0};

    function automatic time_t incr(input time_t t);
        time_t r;
        r = t;
        if (t.sc == 7'd59) begin
            r.sc = 7'd0;
            if (t.mn == 7'd59) begin
                r.mn = 7'd0;
                if (IS24) begin
                    r.hr = (t.hr == 7'd23) ? 7'd0 : t.hr + 7'd1;
                end else if (t.hr == 7'd12) begin
                    r.hr = 7'd1;
                end else begin
                    r.hr = t.hr + 7'd1;
                    r.mer = (t.hr == 7'd11) ? ~t.mer : t.mer;
                end
            end else begin
                r.mn = t.mn + 7'd1;
            end
        end else begin
            r.sc = t.sc + 7'd1;
        end
        return r;
    endfunction

    // Values never exceed 59, so a compare ladder gives the tens digit.
    function automatic logic [7:0] bcd2(input logic [6:0] v);
        logic [3:0] t;
        logic [6:0] u;
        t = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            if (v >= 7'(k * 10)) t = 4'(k);
        end
        u = v - 7'(t) * 7'd10;
        return {t, u[3:0]};
    endfunction

    function automatic logic [7:0] dig_ascii(input logic [3:0] d);
        return (d == 4'hF) ? 8'h5F : 8'h30 + {4'h0, d};
    endfunction

    function automatic logic [255:0] fmt(input state_t st, input logic [5:0][3:0] sh,
                                         input logic shm, input time_t t, input logic armed);
        logic [255:0] r;
        logic [7:0]   hb, mb, sb;
        r  = {32{BLANK_CHAR}};
        hb = bcd2(t.hr);
        mb = bcd2(t.mn);
        sb = bcd2(t.sc);
        if (st != ST_RUN) begin
            r[16 +: 8]  = 8'h53;
            r[24 +: 8]  = 8'h45;
            r[32 +: 8]  = 8'h54;
            r[48 +: 8]  = dig_ascii(sh[0]);
            r[56 +: 8]  = dig_ascii(sh[1]);
            r[64 +: 8]  = 8'h3A;
            r[72 +: 8]  = dig_ascii(sh[2]);
            r[80 +: 8]  = dig_ascii(sh[3]);
            r[88 +: 8]  = 8'h3A;
            r[96 +: 8]  = dig_ascii(sh[4]);
            r[104 +: 8] = dig_ascii(sh[5]);
            r[120 +: 8] = IS24 ? BLANK_CHAR : (shm ? 8'h50 : 8'h41);
        end else begin
            r[127:0] = {16{BLANK_CHAR}};
        end
        if (!IS24) begin
            r[160 +: 8] = t.mer ? 8'h50 : 8'h41;
            r[168 +: 8] = 8'h4D;
        end else begin
            r[160 +: 16] = {2{BLANK_CHAR}};
        end
        r[184 +: 8] = dig_ascii(hb[7:4]);
        r[192 +: 8] = dig_ascii(hb[3:0]);
        r[200 +: 8] = 8'h3A;
        r[208 +: 8] = dig_ascii(mb[7:4]);
        r[216 +: 8] = dig_ascii(mb[3:0]);
        r[224 +: 8] = 8'h3A;
        r[232 +: 8] = dig_ascii(sb[7:4]);
        r[240 +: 8] = dig_ascii(sb[3:0]);
        r[248 +: 8] = armed ? 8'h2A : BLANK_CHAR;
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [5:0][3:0]  sh_q, sh_d;
    logic             sh_mer_q, sh_mer_d;
    logic             tgt_q, tgt_d;
    time_t            time_q, time_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             sec_pulse_q;
    logic             set_active_q;
    logic [255:0]     disp_q, disp_d;

    logic             tick_s, mode_live_s, mode_alarm_s, mode_hold_s;
    logic             sh_ok_s, commit_ok_s, load_live_s, armed_s;
    logic [6:0]       sh_hr_s, sh_mn_s, sh_sc_s;
    time_t            shadow_time_s;

    assign tick_s       = (presc_q == PW'(CLK_HZ - 1));
    assign mode_live_s  = (MODE == 4'b0001);
`ifdef TIME_ALARM_EN
    assign mode_alarm_s = (MODE == 4'b0010);
`else
    assign mode_alarm_s = 1'b0;
`endif
    assign mode_hold_s  = tgt_q ? mode_alarm_s : mode_live_s;

    assign sh_hr_s = 7'(sh_q[0]) * 7'd10 + 7'(sh_q[1]);
    assign sh_mn_s = 7'(sh_q[2]) * 7'd10 + 7'(sh_q[3]);
    assign sh_sc_s = 7'(sh_q[4]) * 7'd10 + 7'(sh_q[5]);
    assign shadow_time_s = '{hr: sh_hr_s, mn: sh_mn_s, sc: sh_sc_s, mer: (IS24 ? 1'b0 : sh_mer_q)};
    assign sh_ok_s = (IS24 ? (sh_hr_s <= 7'd23) : (sh_hr_s >= 7'd1 && sh_hr_s <= 7'd12))
                     && (sh_mn_s <= 7'd59) && (sh_sc_s <= 7'd59);
    assign commit_ok_s = (state_q == ST_COMMIT) && sh_ok_s;
    assign load_live_s = commit_ok_s && !tgt_q;

    // Entry FSM: digit capture into the shadow, meridiem toggle, abort and commit.
    always_comb begin
        state_d  = state_q;
        sh_d     = sh_q;
        sh_mer_d = sh_mer_q;
        tgt_d    = tgt_q;
        case (state_q)
            ST_RUN: begin
                if (mode_live_s || mode_alarm_s) begin
                    state_d  = ST_H10;
                    sh_d     = '1;
                    sh_mer_d = time_q.mer;
                    tgt_d    = mode_alarm_s;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_COMMIT: begin
                if (mode_hold_s) begin
                    state_d  = ST_H10;
                    sh_d     = '1;
                    sh_mer_d = load_live_s ? sh_mer_q : time_q.mer;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_H10, ST_H1, ST_M10, ST_M1, ST_S10, ST_S1: begin
                if (!mode_hold_s) begin
                    state_d = ST_RUN;
                end else if (NUM_VALID && NUM_SYNC <= 4'd9) begin
                    sh_d[3'(state_q) - 3'd1] = NUM_SYNC;
                    state_d = state_t'(state_q + 3'd1);
                end else if (NUM_VALID && NUM_SYNC == 4'hA && !IS24) begin
                    sh_mer_d = ~sh_mer_q;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Time, prescaler and display next state; a commit load overrides a same-edge tick.
    always_comb begin
        time_d  = time_q;
        presc_d = presc_q + PW'(1);
        if (load_live_s) begin
            time_d  = shadow_time_s;
            presc_d = '0;
        end else if (tick_s) begin
            time_d  = incr(time_q);
            presc_d = '0;
        end else begin
            time_d = time_q;
        end
        disp_d = fmt(state_q, sh_q, sh_mer_q, time_q, armed_s);
    end

    // State, time and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_RUN;
            sh_q         <= '1;
            sh_mer_q     <= 1'b0;
            tgt_q        <= 1'b0;
            time_q       <= RESET_TIME;
            presc_q      <= '0;
            sec_pulse_q  <= 1'b0;
            set_active_q <= 1'b0;
            disp_q       <= fmt(ST_RUN, '1, 1'b0, RESET_TIME, 1'b0);
        end else begin
            state_q      <= state_d;
            sh_q         <= sh_d;
            sh_mer_q     <= sh_mer_d;
            tgt_q        <= tgt_d;
            time_q       <= time_d;
            presc_q      <= presc_d;
            sec_pulse_q  <= tick_s;
            set_active_q <= (state_d != ST_RUN);
            disp_q       <= disp_d;
        end
    end

`ifdef TIME_ALARM_EN
    time_t alarm_q;
    logic  armed_q;
    logic  alarm_match_q;

    // Alarm storage and match pulse aligned with SEC_PULSE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            alarm_q       <= RESET_TIME;
            armed_q       <= 1'b0;
            alarm_match_q <= 1'b0;
        end else begin
            if (commit_ok_s && tgt_q) begin
                alarm_q <= shadow_time_s;
                armed_q <= 1'b1;
            end else begin
                alarm_q <= alarm_q;
                armed_q <= armed_q;
            end
            alarm_match_q <= tick_s && !load_live_s && armed_q && (incr(time_q) == alarm_q);
        end
    end

    assign armed_s     = armed_q;
    assign ALARM_MATCH = alarm_match_q;
`else
    assign armed_s = 1'b0;
`endif

    assign TIME_DATA  = disp_q;
    assign MERIDIEM   = time_q.mer;
    assign HOUR       = time_q.hr;
    assign MIN        = time_q.mn;
    assign SEC        = time_q.sc;
    assign SEC_PULSE  = sec_pulse_q;
    assign SET_ACTIVE = set_active_q;

endmodule

// File: tb/tb_rtc_time_display.sv
// Directed bench for rtc_time_display: a 12h and a 24h instance, CLK_HZ=4.
module tb_rtc_time_display;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   num;
    logic         valid;
    logic [3:0]   mode12, mode24;

    logic [255:0] td12, td24;
    logic         mer12, mer24, sp12, sp24, sa12, sa24;
    logic [6:0]   hr12, mn12, sc12, hr24, mn24, sc24;

    int checks   = 0;
    int failures = 0;

    rtc_time_display #(.CLK_HZ(4), .MODE_24H(0)) dut12 (
        .CLK(clk), .RESET(rst), .NUM_SYNC(num), .NUM_VALID(valid), .MODE(mode12),
        .TIME_DATA(td12), .MERIDIEM(mer12), .HOUR(hr12), .MIN(mn12), .SEC(sc12),
        .SEC_PULSE(sp12), .SET_ACTIVE(sa12)
    );

    rtc_time_display #(.CLK_HZ(4), .MODE_24H(1)) dut24 (
        .CLK(clk), .RESET(rst), .NUM_SYNC(num), .NUM_VALID(valid), .MODE(mode24),
        .TIME_DATA(td24), .MERIDIEM(mer24), .HOUR(hr24), .MIN(mn24), .SEC(sc24),
        .SEC_PULSE(sp24), .SET_ACTIVE(sa24)
    );

    always #5 clk = ~clk;

    // Leftmost LCD cell of the line ends up in the most significant byte, like a string literal.
    function automatic logic [127:0] line(input logic [255:0] td, input int ln);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = td[8*(16*ln+i) +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] code);
        num   = code;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic enter6(input logic [23:0] digs);
        for (int i = 0; i < 6; i++) press(digs[4*(5-i) +: 4]);
    endtask

    initial begin
        rst = 1'b1; num = 4'h0; valid = 1'b0; mode12 = 4'h0; mode24 = 4'h0;
        @(negedge clk);
        chk("rst_hour12", {121'd0, hr12}, 128'd12);
        chk("rst_min12", {121'd0, mn12}, 128'd0);
        chk("rst_sec12", {121'd0, sc12}, 128'd0);
        chk("rst_mer12", {127'd0, mer12}, 128'd0);
        chk("rst_pulse12", {127'd0, sp12}, 128'd0);
        chk("rst_set12", {127'd0, sa12}, 128'd0);
        chk("rst_line1_12", line(td12, 0), "                ");
        chk("rst_line2_12", line(td12, 1), "    AM 12:00:00 ");
        chk("rst_hour24", {121'd0, hr24}, 128'd0);
        chk("rst_set24", {127'd0, sa24}, 128'd0);
        chk("rst_line2_24", line(td24, 1), "       00:00:00 ");
        rst = 1'b0;

        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("pulse_c%0d", c), {127'd0, sp12}, {127'd0, (c % 4 == 0)});
            if (c == 4) chk("sec_after_first", {121'd0, sc12}, 128'd1);
            if (c == 5) chk("line2_1s", line(td12, 1), "    AM 12:00:01 ");
            if (c == 8) chk("sec_after_second", {121'd0, sc12}, 128'd2);
        end

        // 11:59:59 AM rolls to 12:00:00 PM
        mode12 = 4'b0001;
        @(negedge clk);
        enter6(24'h115959);
        mode12 = 4'b0000;
        @(negedge clk);
        chk("load_11_hour", {121'd0, hr12}, 128'd11);
        chk("load_11_sec", {121'd0, sc12}, 128'd59);
        chk("load_11_set", {127'd0, sa12}, 128'd0);
        repeat (3) @(negedge clk);
        chk("presc_clear_nopulse", {127'd0, sp12}, 128'd0);
        @(negedge clk);
        chk("roll11_hour", {121'd0, hr12}, 128'd12);
        chk("roll11_min", {121'd0, mn12}, 128'd0);
        chk("roll11_sec", {121'd0, sc12}, 128'd0);
        chk("roll11_mer", {127'd0, mer12}, 128'd1);
        chk("roll11_pulse", {127'd0, sp12}, 128'd1);

        // 12:59:59 PM rolls to 01:00:00 PM
        mode12 = 4'b0001;
        @(negedge clk);
        enter6(24'h125959);
        mode12 = 4'b0000;
        @(negedge clk);
        chk("load_12_mer", {127'd0, mer12}, 128'd1);
        repeat (4) @(negedge clk);
        chk("roll12_hour", {121'd0, hr12}, 128'd1);
        chk("roll12_min", {121'd0, mn12}, 128'd0);
        chk("roll12_mer", {127'd0, mer12}, 128'd1);
        @(negedge clk);
        chk("roll12_line2", line(td12, 1), "    PM 01:00:00 ");

        // 24h: 23:59:59 rolls to 00:00:00
        mode24 = 4'b0001;
        @(negedge clk);
        enter6(24'h235959);
        mode24 = 4'b0000;
        @(negedge clk);
        chk("load_23_hour", {121'd0, hr24}, 128'd23);
        repeat (4) @(negedge clk);
        chk("roll23_hour", {121'd0, hr24}, 128'd0);
        chk("roll23_min", {121'd0, mn24}, 128'd0);
        chk("roll23_sec", {121'd0, sc24}, 128'd0);
        chk("roll23_mer", {127'd0, mer24}, 128'd0);
        chk("roll23_pulse", {127'd0, sp24}, 128'd1);
        @(negedge clk);
        chk("roll23_line2", line(td24, 1), "       00:00:00 ");

        // Full entry 09:30:45 with meridiem toggle (live is PM)
        mode12 = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("entry_blank", line(td12, 0), "  SET __:__:__ P");
        press(4'hA);
        press(4'hB);
        press(4'h0);
        @(negedge clk);
        chk("entry_h10", line(td12, 0), "  SET 0_:__:__ A");
        press(4'h9);
        press(4'h3);
        press(4'h0);
        @(negedge clk);
        chk("entry_m1", line(td12, 0), "  SET 09:30:__ A");
        chk("entry_active", {127'd0, sa12}, 128'd1);
        press(4'h4);
        press(4'h5);
        mode12 = 4'b0000;
        @(negedge clk);
        chk("commit_hour", {121'd0, hr12}, 128'd9);
        chk("commit_min", {121'd0, mn12}, 128'd30);
        chk("commit_sec", {121'd0, sc12}, 128'd45);
        chk("commit_mer", {127'd0, mer12}, 128'd0);
        chk("commit_set", {127'd0, sa12}, 128'd0);
        repeat (3) @(negedge clk);
        chk("commit_presc_sec", {121'd0, sc12}, 128'd45);
        chk("commit_presc_nopulse", {127'd0, sp12}, 128'd0);
        @(negedge clk);
        chk("commit_tick_sec", {121'd0, sc12}, 128'd46);
        chk("commit_tick_pulse", {127'd0, sp12}, 128'd1);

        // Invalid 13:00:00 in 12h is rejected
        mode12 = 4'b0001;
        @(negedge clk);
        enter6(24'h130000);
        mode12 = 4'b0000;
        @(negedge clk);
        chk("reject_hour", {121'd0, hr12}, 128'd9);
        chk("reject_min", {121'd0, mn12}, 128'd30);
        chk("reject_set", {127'd0, sa12}, 128'd0);

        // MODE drop after two digits aborts without load
        mode12 = 4'b0001;
        @(negedge clk);
        press(4'h1);
        press(4'h1);
        mode12 = 4'b0000;
        @(negedge clk);
        chk("abort_set", {127'd0, sa12}, 128'd0);
        chk("abort_hour", {121'd0, hr12}, 128'd9);
        @(negedge clk);
        chk("abort_line1", line(td12, 0), "                ");

        // Reset asserted mid-entry
        mode12 = 4'b0001;
        @(negedge clk);
        press(4'h0);
        press(4'h5);
        rst = 1'b1;
        #1;
        chk("midrst_hour", {121'd0, hr12}, 128'd12);
        chk("midrst_min", {121'd0, mn12}, 128'd0);
        chk("midrst_sec", {121'd0, sc12}, 128'd0);
        chk("midrst_mer", {127'd0, mer12}, 128'd0);
        chk("midrst_set", {127'd0, sa12}, 128'd0);
        chk("midrst_pulse", {127'd0, sp12}, 128'd0);
        chk("midrst_line1", line(td12, 0), "                ");
        chk("midrst_line2", line(td12, 1), "    AM 12:00:00 ");
        chk("midrst_hour24", {121'd0, hr24}, 128'd0);
        mode12 = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("postrst_set", {127'd0, sa12}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
